// File: rtl/wb_writeback_arb_if.sv
// rtl/wb_writeback_arb_if.sv - GPR writeback arbiter bus (pipe, long-latency handshake, GPR write port); WB_PENDING_CHECK_EN adds chk_* signals
interface wb_writeback_arb_if #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int FIFO_DEPTH = 4
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic              pipe_we_i;
   logic [ADDR_W-1:0] pipe_addr_i;
   logic [DATA_W-1:0] pipe_wdata_i;
   logic              lsu_valid_i;
   logic [ADDR_W-1:0] lsu_addr_i;
   logic [DATA_W-1:0] lsu_wdata_i;
   logic              lsu_ready_o;
   logic              stall_req_o;
   logic              rd_we_o;
   logic [ADDR_W-1:0] rd_addr_o;
   logic [DATA_W-1:0] rd_wdata_o;
   logic [CNT_W-1:0]  fifo_count_o;
`ifdef WB_PENDING_CHECK_EN
   logic [ADDR_W-1:0] chk_addr_i;
   logic              chk_pending_o;

   modport master (
      output pipe_we_i, pipe_addr_i, pipe_wdata_i,
      output lsu_valid_i, lsu_addr_i, lsu_wdata_i,
      input  lsu_ready_o, stall_req_o,
      input  rd_we_o, rd_addr_o, rd_wdata_o, fifo_count_o,
      output chk_addr_i,
      input  chk_pending_o
   );

   modport slave (
      input  pipe_we_i, pipe_addr_i, pipe_wdata_i,
      input  lsu_valid_i, lsu_addr_i, lsu_wdata_i,
      output lsu_ready_o, stall_req_o,
      output rd_we_o, rd_addr_o, rd_wdata_o, fifo_count_o,
      input  chk_addr_i,
      output chk_pending_o
   );
`else
   modport master (
      output pipe_we_i, pipe_addr_i, pipe_wdata_i,
      output lsu_valid_i, lsu_addr_i, lsu_wdata_i,
      input  lsu_ready_o, stall_req_o,
      input  rd_we_o, rd_addr_o, rd_wdata_o, fifo_count_o
   );

   modport slave (
      input  pipe_we_i, pipe_addr_i, pipe_wdata_i,
      input  lsu_valid_i, lsu_addr_i, lsu_wdata_i,
      output lsu_ready_o, stall_req_o,
      output rd_we_o, rd_addr_o, rd_wdata_o, fifo_count_o
   );
`endif
endinterface

// File: rtl/wb_writeback_arb.sv
// rtl/wb_writeback_arb.sv - GPR write port arbiter: pipe result has priority over a buffered long-latency FIFO; WB_PENDING_CHECK_EN adds pending-address lookup
module wb_writeback_arb #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic               clk_i,
   input  logic               n_rst_i,
   wb_writeback_arb_if.slave  bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ST_W  = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [ST_W-1:0]  ST_MAX   = ST_W'(STARVE_LIMIT);

   logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [ST_W-1:0]   starve;
   logic              stall_req;
   logic              rd_we;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_wdata;

   logic pipe_req;
   logic lsu_ready;
   logic push;
   logic pop;
   logic fifo_empty;

   // Ready comes from the registered count only, so a same-cycle pop never opens a full FIFO.
   assign fifo_empty = (count == '0);
   assign lsu_ready  = (count != FULL_CNT);
   // Writes to x0 are dropped at the source: pipe x0 is no request, lsu x0 completes but is not stored.
   assign pipe_req   = bus.pipe_we_i && (bus.pipe_addr_i != '0);
   assign push       = bus.lsu_valid_i && lsu_ready && (bus.lsu_addr_i != '0);
   assign pop        = !pipe_req && !fifo_empty;

   // FIFO payload storage; only the pointers need reset.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_addr[wr_ptr] <= bus.lsu_addr_i;
         fifo_data[wr_ptr] <= bus.lsu_wdata_i;
      end
   end

   // FIFO bookkeeping, starvation tracking and the registered GPR write port.
   always_ff @(posedge clk_i or negedge n_rst_i) begin
      if (!n_rst_i) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         starve    <= '0;
         stall_req <= 1'b0;
         rd_we     <= 1'b0;
         rd_addr   <= '0;
         rd_wdata  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         // Count cycles the buffered head loses to the pipe; saturate so a
         // contract-violating pipe keeps the stall asserted.
         if (pop || fifo_empty) begin
            starve <= '0;
         end else if (pipe_req && (starve != ST_MAX)) begin
            starve <= starve + 1'b1;
         end

         stall_req <= !pop && !fifo_empty && (starve == ST_MAX);

         rd_we <= pipe_req || pop;
         if (pipe_req) begin
            rd_addr  <= bus.pipe_addr_i;
            rd_wdata <= bus.pipe_wdata_i;
         end else if (pop) begin
            rd_addr  <= fifo_addr[rd_ptr];
            rd_wdata <= fifo_data[rd_ptr];
         end
      end
   end

   assign bus.lsu_ready_o  = lsu_ready;
   assign bus.stall_req_o  = stall_req;
   assign bus.rd_we_o      = rd_we;
   assign bus.rd_addr_o    = rd_addr;
   assign bus.rd_wdata_o   = rd_wdata;
   assign bus.fifo_count_o = count;

`ifdef WB_PENDING_CHECK_EN
   logic             chk_hit;
   logic [PTR_W-1:0] chk_idx;

   // An address is pending while it sits in a live FIFO slot or is being written this cycle.
   always_comb begin
      chk_hit = 1'b0;
      chk_idx = '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         chk_idx = rd_ptr + PTR_W'(i);
         if ((CNT_W'(i) < count) && (fifo_addr[chk_idx] == bus.chk_addr_i)) begin
            chk_hit = 1'b1;
         end
      end
      if (rd_we && (rd_addr == bus.chk_addr_i)) begin
         chk_hit = 1'b1;
      end
      if (bus.chk_addr_i == '0) begin
         chk_hit = 1'b0;
      end
   end

   assign bus.chk_pending_o = chk_hit;
`endif
endmodule

// File: tb/tb_wb_writeback_arb.sv
// tb/tb_wb_writeback_arb.sv - scoreboard bench for wb_writeback_arb
module tb_wb_writeback_arb;
   logic clk;
   logic n_rst;
   int   cyc;
   int   total;
   int   bad;

   typedef struct {
      int          due;
      logic [4:0]  addr;
      logic [31:0] data;
   } pipe_exp_t;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
   } lsu_exp_t;

   pipe_exp_t pipe_q [$];
   lsu_exp_t  lsu_q [$];

   wb_writeback_arb_if #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(4)) bus ();

   wb_writeback_arb #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(4), .STARVE_LIMIT(3)) dut (
      .clk_i   (clk),
      .n_rst_i (n_rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One cycle of stimulus: drive after the edge, return at the following falling edge.
   task automatic step(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic exp_rdy);
      pipe_exp_t pe;
      lsu_exp_t  le;
      @(posedge clk);
      #1;
      bus.pipe_we_i    = pw;
      bus.pipe_addr_i  = pa;
      bus.pipe_wdata_i = pd;
      bus.lsu_valid_i  = lv;
      bus.lsu_addr_i   = la;
      bus.lsu_wdata_i  = ld;
      if (pw && pa != 5'd0) begin
         pe.due = cyc + 1; pe.addr = pa; pe.data = pd;
         pipe_q.push_back(pe);
      end
      if (lv) begin
         check("lsu_ready", bus.lsu_ready_o, exp_rdy);
         if (exp_rdy && la != 5'd0) begin
            le.addr = la; le.data = ld;
            lsu_q.push_back(le);
         end
      end
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1);
   endtask

   // Scoreboard: pipe writes are due exactly one cycle after issue, otherwise FIFO order.
   always @(negedge clk) begin
      if (n_rst) begin
         if (pipe_q.size() != 0 && pipe_q[0].due == cyc) begin
            check("pipe_we", bus.rd_we_o, 1'b1);
            check("pipe_addr", bus.rd_addr_o, pipe_q[0].addr);
            check("pipe_data", bus.rd_wdata_o, pipe_q[0].data);
            void'(pipe_q.pop_front());
         end else if (bus.rd_we_o) begin
            if (lsu_q.size() == 0) begin
               check("spurious_we", bus.rd_we_o, 1'b0);
            end else begin
               check("lsu_addr", bus.rd_addr_o, lsu_q[0].addr);
               check("lsu_data", bus.rd_wdata_o, lsu_q[0].data);
               void'(lsu_q.pop_front());
            end
         end
      end
   end

   initial begin
      total = 0;
      bad   = 0;
      cyc   = 0;
      n_rst = 1'b0;
      bus.pipe_we_i    = 1'b0;
      bus.pipe_addr_i  = '0;
      bus.pipe_wdata_i = '0;
      bus.lsu_valid_i  = 1'b0;
      bus.lsu_addr_i   = '0;
      bus.lsu_wdata_i  = '0;
`ifdef WB_PENDING_CHECK_EN
      bus.chk_addr_i   = '0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_we", bus.rd_we_o, 1'b0);
      check("rst_addr", bus.rd_addr_o, 5'd0);
      check("rst_data", bus.rd_wdata_o, 32'd0);
      check("rst_stall", bus.stall_req_o, 1'b0);
      check("rst_count", bus.fifo_count_o, 3'd0);
      @(posedge clk);
      #1 n_rst = 1'b1;
      @(negedge clk);
      check("rst_ready", bus.lsu_ready_o, 1'b1);

      // Pipe write: visible the next cycle for one cycle.
      step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1);
      idle(1);
      check("pipe_lat_we", bus.rd_we_o, 1'b1);
      idle(1);
      check("pipe_after_we", bus.rd_we_o, 1'b0);

      // Long-latency write: two cycles after the handshake.
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12345678, 1'b1);
      idle(1);
      check("lsu_cnt1", bus.fifo_count_o, 3'd1);
      check("lsu_lat_we0", bus.rd_we_o, 1'b0);
      idle(1);
      check("lsu_lat_we1", bus.rd_we_o, 1'b1);
      check("lsu_cnt0", bus.fifo_count_o, 3'd0);
      idle(1);

      // Starvation: pipe holds the port while four entries fill the FIFO.
      step(1'b1, 5'd3, 32'h30, 1'b1, 5'd21, 32'hA1, 1'b1);
      check("stv_cnt0", bus.fifo_count_o, 3'd0);
      step(1'b1, 5'd3, 32'h31, 1'b1, 5'd22, 32'hA2, 1'b1);
      check("stv_stall_a1", bus.stall_req_o, 1'b0);
      step(1'b1, 5'd3, 32'h32, 1'b1, 5'd23, 32'hA3, 1'b1);
      step(1'b1, 5'd3, 32'h33, 1'b1, 5'd24, 32'hA4, 1'b1);
      check("stv_stall_a3", bus.stall_req_o, 1'b0);
      step(1'b1, 5'd3, 32'h34, 1'b0, 5'd0, 32'd0, 1'b1);
      check("stv_cnt4", bus.fifo_count_o, 3'd4);
      check("stv_full", bus.lsu_ready_o, 1'b0);
      check("stv_stall_a4", bus.stall_req_o, 1'b0);
      step(1'b1, 5'd3, 32'h35, 1'b0, 5'd0, 32'd0, 1'b1);
      check("stv_stall_a5", bus.stall_req_o, 1'b1);
      step(1'b1, 5'd3, 32'h36, 1'b0, 5'd0, 32'd0, 1'b1);
      check("stv_stall_a6", bus.stall_req_o, 1'b1);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd25, 32'hA5, 1'b0);
      check("stv_stall_pop", bus.stall_req_o, 1'b1);
      check("stv_cnt_pop", bus.fifo_count_o, 3'd4);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd25, 32'hA5, 1'b1);
      check("stv_stall_clr", bus.stall_req_o, 1'b0);
      check("stv_cnt3", bus.fifo_count_o, 3'd3);
      idle(6);
      check("stv_drained", bus.fifo_count_o, 3'd0);

      // x0 on both sources: handshake completes, nothing buffered or written.
      step(1'b1, 5'd0, 32'hBAD0, 1'b1, 5'd0, 32'hBAD1, 1'b1);
      idle(1);
      check("x0_cnt", bus.fifo_count_o, 3'd0);
      check("x0_we", bus.rd_we_o, 1'b0);
      idle(1);
      check("x0_we2", bus.rd_we_o, 1'b0);

      // Interleaved traffic with random payloads.
      for (int k = 0; k < 10; k++) begin
         if (k % 2 == 0)
            step(1'b1, 5'($urandom_range(31, 1)), $urandom, 1'b0, 5'd0, 32'd0, 1'b1);
         else
            step(1'b0, 5'd0, 32'd0, 1'b1, 5'($urandom_range(31, 1)), $urandom, 1'b1);
      end
      idle(4);
      check("mix_cnt", bus.fifo_count_o, 3'd0);

`ifdef WB_PENDING_CHECK_EN
      bus.chk_addr_i = 5'd9;
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b1);
      check("pend_n0", bus.chk_pending_o, 1'b0);
      idle(1);
      check("pend_fifo", bus.chk_pending_o, 1'b1);
      idle(1);
      check("pend_rd", bus.chk_pending_o, 1'b1);
      idle(1);
      check("pend_done", bus.chk_pending_o, 1'b0);
      bus.chk_addr_i = 5'd0;
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h98, 1'b1);
      idle(1);
      check("pend_x0_fifo", bus.chk_pending_o, 1'b0);
      idle(1);
      check("pend_x0_rd", bus.chk_pending_o, 1'b0);
      idle(1);
`endif

      // Reset with two buffered entries: outputs clear at once, entries never written.
      step(1'b1, 5'd3, 32'h40, 1'b1, 5'd10, 32'hB0, 1'b1);
      step(1'b1, 5'd3, 32'h41, 1'b1, 5'd11, 32'hB1, 1'b1);
      step(1'b1, 5'd3, 32'h42, 1'b0, 5'd0, 32'd0, 1'b1);
      check("pre_rst_cnt", bus.fifo_count_o, 3'd2);
      @(posedge clk);
      #2;
      bus.pipe_we_i   = 1'b0;
      bus.lsu_valid_i = 1'b0;
      check("pre_rst_we", bus.rd_we_o, 1'b1);
      n_rst = 1'b0;
      pipe_q.delete();
      lsu_q.delete();
      #1;
      check("mid_rst_we", bus.rd_we_o, 1'b0);
      check("mid_rst_addr", bus.rd_addr_o, 5'd0);
      check("mid_rst_data", bus.rd_wdata_o, 32'd0);
      check("mid_rst_stall", bus.stall_req_o, 1'b0);
      check("mid_rst_cnt", bus.fifo_count_o, 3'd0);
      @(posedge clk);
      #1 n_rst = 1'b1;
      idle(8);
      check("post_rst_cnt", bus.fifo_count_o, 3'd0);
      check("post_rst_ready", bus.lsu_ready_o, 1'b1);

      check("lsu_q_empty", lsu_q.size(), 0);
      check("pipe_q_empty", pipe_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/wb_writeback_arb.md
Name: wb_writeback_arb

Overview:
- Writer-side front end of the GPR write port.
- Merges two result sources onto the single GPR write port (rd_we/rd_addr/rd_wdata):
  - the in-order pipeline result from the mem stage, which has no backpressure;
  - a long-latency source (load/divider), accepted through a valid/ready handshake and buffered in a small FIFO.
- The pipeline source has priority; a starvation counter requests a pipeline stall so buffered results drain.

Parameters:
- DATA_W, 32, GPR data width.
- ADDR_W, 5, GPR address width.
- FIFO_DEPTH, 4, long-latency result buffer entries (power of 2, >=2).
- STARVE_LIMIT, 3, consecutive cycles a non-empty FIFO loses arbitration before stall_req_o asserts.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- n_rst_i  in  1  asynchronous active-low reset.
- pipe_we_i  in  1  mem-stage result valid; always accepted.
- pipe_addr_i  in  ADDR_W  mem-stage destination register.
- pipe_wdata_i  in  DATA_W  mem-stage result.
- lsu_valid_i  in  1  long-latency result valid.
- lsu_addr_i  in  ADDR_W  long-latency destination register.
- lsu_wdata_i  in  DATA_W  long-latency result.
- lsu_ready_o  out  1  FIFO can accept.
- stall_req_o  out  1  request the pipeline to stop issuing writebacks.
- rd_we_o  out  1  GPR write enable.
- rd_addr_o  out  ADDR_W  GPR write address.
- rd_wdata_o  out  DATA_W  GPR write data.
- fifo_count_o  out  log2(FIFO_DEPTH)+1  buffered entries.

Behaviour:
- Reset (n_rst_i low, asynchronous):
  - rd_we_o=0, rd_addr_o=0, rd_wdata_o=0, stall_req_o=0, fifo_count_o=0.
  - FIFO pointers cleared and starve counter=0.
  - lsu_ready_o=1 once out of reset.
  - Reset mid-operation discards all buffered entries; no write is issued for them.
- Handshake and FIFO push:
  - lsu_ready_o = (count != FIFO_DEPTH), derived from registered count only.
  - Push when lsu_valid_i & lsu_ready_o.
  - Push and pop in the same cycle: count unchanged.
  - When full, the handshake stalls even if a pop occurs that cycle.
- x0 handling:
  - Entries with address 0 are never written to the GPR.
  - pipe_we_i with pipe_addr_i==0 is treated as no request.
  - A handshake with lsu_addr_i==0 completes but is not pushed.
- Arbitration (combinational select, registered output):
  - If pipe request is valid: pipe wins and the FIFO head waits.
  - Else if FIFO is non-empty: head is popped.
  - Else: no write.
  - The winner is registered into rd_*; rd_we_o=0 in cycles with no winner.
- Latency:
  - Pipe request at cycle N: rd_* valid in cycle N+1.
  - Long-latency handshake at cycle N, empty FIFO, no pipe request: rd_* valid in cycle N+2.
- Ordering:
  - FIFO is strict first-in first-out.
  - Ordering between the two sources is not enforced here; the issue logic guarantees no WAW between them.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and pipe wins, saturating at STARVE_LIMIT.
  - It clears on any pop or when the FIFO is empty.
  - stall_req_o is registered: 1 the cycle after the counter reaches STARVE_LIMIT, 0 the cycle after the next pop.
  - The pipeline contract is pipe_we_i=0 while stall_req_o=1.
  - If violated, pipe still wins; no data is lost, and the counter stays saturated.
- Write-data forwarding to readers is performed downstream by the GPR itself; this block adds none.

Optional Feature:
- Macro WB_PENDING_CHECK_EN.
- Defined:
  - Adds ports chk_addr_i (in, ADDR_W) and chk_pending_o (out, 1).
  - chk_pending_o is combinational.
  - chk_pending_o = 1 when chk_addr_i!=0 and it matches any valid FIFO entry or the registered rd_addr_o with rd_we_o=1.
  - Issue logic uses it to stall RAW on buffered results.
- Undefined: ports absent and no comparators.

Test Plan:
- Reset, then pipe_we_i=1, addr=5, data=0xDEADBEEF at cycle 1 -> cycle 2: rd_we_o=1, rd_addr_o=5, rd_wdata_o=0xDEADBEEF; cycle 3: rd_we_o=0.
- lsu handshake addr=7, data=0x12345678, idle pipe -> rd_* write of x7 exactly 2 cycles after the handshake; fifo_count_o returns 1->0.
- Hold pipe_we_i=1 (addr=3) continuously with 4 lsu pushes:
  - lsu_ready_o=0 after the 4th push and fifo_count_o=4;
  - stall_req_o=1 on the 4th cycle after the FIFO becomes non-empty;
  - dropping pipe_we_i drains entries in push order;
  - stall_req_o returns to 0 the cycle after the first pop.
- Push with lsu_addr_i=0 and pipe_we_i with addr 0 -> handshake completes, fifo_count_o unchanged, rd_we_o stays 0.
- FIFO holding 2 entries, assert n_rst_i=0 mid-cycle -> all outputs 0 immediately; after release, no write of the discarded entries ever appears.
- With WB_PENDING_CHECK_EN: push addr=9, chk_addr_i=9 -> chk_pending_o=1 until the cycle after the x9 write leaves rd_*; chk_addr_i=0 -> chk_pending_o=0 throughout.
